pipe_adder: RTL and testbench

- Parametrised, pipelined successor of the 4-bit-group lookahead adder chain.
- Splits the operand width into STAGES segments. Each segment is a chain of GROUP-bit carry-lookahead groups, and one segment's carry is resolved per clock.
- Adds subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure.
- Sits between operand-select and writeback in the multi-cycle datapath. It is also used standalone for address/PC arithmetic when BITWIDTH is large.

---
 rtl/pipe_adder.sv | 180 ++++++++++++++++++
 tb/tb_pipe_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined, parametrised two's-complement adder/subtractor.
//
// The operand width is cut into STAGES equal segments. Stage k adds segment
// k with a chain of GROUP-bit carry-lookahead groups, starting from the
// carry left by stage k-1. It registers the finished low-order sum bits,
// the carry into segment k+1, and the conditioned operands. The last stage
// also registers the overflow and zero flags.
//
// Ports:
//   clk, rst        sole clock; synchronous active-high reset
//   in_valid/ready  operand beat handshake (augend, addend, cin, sub)
//   out_valid/ready result beat handshake (sum, cout, overflow, zero)
//   sub=1           augend - addend (cin ignored); sub=0: augend+addend+cin
//   cout            raw carry out of the MSB (NOT-borrow when subtracting)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. Once out_valid is high, the result is held stable until out_ready
// takes it. A stage accepts new data when it is empty, or when its contents
// move on in the same cycle. in_ready is therefore a combinational function
// of out_ready through the valid chain; there is no skid buffer.
module pipe_adder #(
   parameter int BITWIDTH = 32,
   parameter int STAGES   = 2,
   parameter int GROUP    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] augend,
   input  logic [BITWIDTH-1:0] addend,
   input  logic                cin,
   input  logic                sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] sum,
   output logic                cout,
   output logic                overflow,
   output logic                zero
);

   localparam int SEG  = BITWIDTH / STAGES;
   localparam int NGRP = SEG / GROUP;
   localparam int LAST = STAGES - 1;
   localparam int MSB  = BITWIDTH - 1;

   if (GROUP < 1 || STAGES < 1 || STAGES > BITWIDTH / GROUP) begin : g_bad_stages
      $error("pipe_adder: STAGES must be in 1..BITWIDTH/GROUP");
   end
   if (BITWIDTH % (STAGES * GROUP) != 0) begin : g_bad_width
      $error("pipe_adder: BITWIDTH must be divisible by STAGES*GROUP");
   end

   // One segment: NGRP lookahead groups, rippled group to group.
   // Inside a group, each carry is expanded as a sum of products:
   //   c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cg
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           c_in);
      logic [SEG-1:0] p, g, s;
      logic [GROUP:0] c;
      logic           cg, term;
      p  = a ^ b;
      g  = a & b;
      s  = '0;
      cg = c_in;
      for (int gi = 0; gi < NGRP; gi++) begin
         for (int i = 0; i <= GROUP; i++) begin
            c[i] = cg;
            for (int m = 0; m < i; m++) c[i] = c[i] & p[gi*GROUP+m];
            for (int j = 0; j < i; j++) begin
               term = g[gi*GROUP+j];
               for (int m = j + 1; m < i; m++) term = term & p[gi*GROUP+m];
               c[i] = c[i] | term;
            end
         end
         for (int i = 0; i < GROUP; i++) s[gi*GROUP+i] = p[gi*GROUP+i] ^ c[i];
         cg = c[GROUP];
      end
      return {cg, s};
   endfunction

   // Pipeline registers, one set per stage.
   logic [STAGES-1:0]   v;
   logic [BITWIDTH-1:0] r_sum [STAGES];
   logic [BITWIDTH-1:0] r_a   [STAGES];
   logic [BITWIDTH-1:0] r_b   [STAGES];
   logic [STAGES-1:0]   r_c;
   logic                r_ovf, r_zero;

   // Stage inputs and combinational results.
   logic [BITWIDTH-1:0] st_a   [STAGES];
   logic [BITWIDTH-1:0] st_b   [STAGES];
   logic [BITWIDTH-1:0] st_lo  [STAGES];
   logic [STAGES-1:0]   st_c, st_v;
   logic [BITWIDTH-1:0] nxt_sum [STAGES];
   logic [STAGES-1:0]   nxt_c;
   logic                nxt_ovf, nxt_zero;
   logic [STAGES-1:0]   take;

   // take[k]: stage k loads this cycle. This happens when stage k is empty,
   // or when its occupant moves on (the successor takes it, or the consumer
   // takes it from the last stage).
   always_comb begin : ready_chain
      logic downstream;
      take       = '0;
      downstream = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         take[k]    = !v[k] || downstream;
         downstream = take[k];
      end
   end

   assign in_ready = take[0];

   always_comb begin : datapath
      logic [SEG:0] seg_res;
      // Subtraction is augend + ~addend + 1; cin plays no part in it.
      st_a[0]  = augend;
      st_b[0]  = sub ? ~addend : addend;
      st_c[0]  = sub | cin;
      st_lo[0] = '0;
      st_v[0]  = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         st_a[k]  = r_a[k-1];
         st_b[k]  = r_b[k-1];
         st_c[k]  = r_c[k-1];
         st_lo[k] = r_sum[k-1];
         st_v[k]  = v[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         seg_res    = seg_add(st_a[k][k*SEG +: SEG], st_b[k][k*SEG +: SEG], st_c[k]);
         nxt_sum[k] = st_lo[k];
         nxt_sum[k][k*SEG +: SEG] = seg_res[SEG-1:0];
         nxt_c[k]   = seg_res[SEG];
      end
      nxt_ovf  = (st_a[LAST][MSB] == st_b[LAST][MSB]) &&
                 (nxt_sum[LAST][MSB] != st_a[LAST][MSB]);
      nxt_zero = (nxt_sum[LAST] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v      <= '0;
         r_c    <= '0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_sum[k] <= '0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (take[k]) begin
               v[k] <= st_v[k];
               // Data is captured only with a valid beat; an empty stage
               // keeps stale contents.
               if (st_v[k]) begin
                  r_sum[k] <= nxt_sum[k];
                  r_a[k]   <= st_a[k];
                  r_b[k]   <= st_b[k];
                  r_c[k]   <= nxt_c[k];
               end
            end
         end
         if (take[LAST] && st_v[LAST]) begin
            r_ovf  <= nxt_ovf;
            r_zero <= nxt_zero;
         end
      end
   end

   assign out_valid = v[LAST];
   assign sum       = r_sum[LAST];
   assign cout      = r_c[LAST];
   assign overflow  = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: drives five pipe_adder configurations from one shared
// stimulus stream. Instance 0 (32 bits, 2 stages) gets directed checks.
// Every instance has a scoreboard fed from an arithmetic reference model.
module tb_pipe_adder;

   localparam int NI = 5;

   function automatic int bw_of(input int i);
      case (i)
         0: return 32;
         1: return 32;
         2: return 32;
         3: return 64;
         default: return 16;
      endcase
   endfunction

   function automatic int st_of(input int i);
      case (i)
         0: return 2;
         1: return 1;
         2: return 4;
         3: return 4;
         default: return 2;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, cin, sub;
   logic [63:0] op_a, op_b;

   int          n_assert = 0;
   int          n_fail   = 0;
   bit          sweep_on = 1'b0;
   int          sweep_cyc = 0;

   logic [NI-1:0] o_valid, o_inrdy, o_cout, o_ovf, o_zero;
   logic [63:0]   o_sum [NI];
   int            res_cnt [NI];
   int            q_len [NI];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int BW = bw_of(gi);
      localparam int ST = st_of(gi);

      logic [BW-1:0] s_sum;
      logic          s_valid, s_inrdy, s_cout, s_ovf, s_zero;
      logic [66:0]   exp_q [$];

      pipe_adder #(.BITWIDTH(BW), .STAGES(ST), .GROUP(4)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid),
         .in_ready (s_inrdy),
         .augend   (op_a[BW-1:0]),
         .addend   (op_b[BW-1:0]),
         .cin      (cin),
         .sub      (sub),
         .out_valid(s_valid),
         .out_ready(out_ready),
         .sum      (s_sum),
         .cout     (s_cout),
         .overflow (s_ovf),
         .zero     (s_zero)
      );

      assign o_valid[gi] = s_valid;
      assign o_inrdy[gi] = s_inrdy;
      assign o_cout[gi]  = s_cout;
      assign o_ovf[gi]   = s_ovf;
      assign o_zero[gi]  = s_zero;
      assign o_sum[gi]   = 64'(s_sum);

      // Reference: {cout, overflow, zero, sum} from plain wide arithmetic.
      function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                            input logic c, input logic sb);
         logic [BW-1:0] aa, bb;
         logic [BW:0]   full;
         logic          ov;
         aa   = a[BW-1:0];
         bb   = sb ? ~b[BW-1:0] : b[BW-1:0];
         full = {1'b0, aa} + {1'b0, bb} + (BW+1)'(sb ? 1'b1 : c);
         ov   = (aa[BW-1] == bb[BW-1]) && (full[BW-1] != aa[BW-1]);
         return {full[BW], ov, (full[BW-1:0] == '0), 64'(full[BW-1:0])};
      endfunction

      initial res_cnt[gi] = 0;

      always @(negedge clk) begin
         if (rst) begin
            exp_q.delete();
         end else begin
            if (sweep_on) begin
               chk($sformatf("sb%0d_sweep_in_ready", gi), 67'(s_inrdy), 67'(1));
               if (sweep_cyc >= ST)
                  chk($sformatf("sb%0d_sweep_out_valid", gi), 67'(s_valid), 67'(1));
            end
            if (s_valid) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("sb%0d_spurious_out", gi), 67'(s_valid), 67'(0));
               end else begin
                  chk($sformatf("sb%0d_result", gi),
                      {s_cout, s_ovf, s_zero, 64'(s_sum)}, exp_q[0]);
                  if (out_ready) begin
                     void'(exp_q.pop_front());
                     res_cnt[gi]++;
                  end
               end
            end
            if (in_valid && s_inrdy) exp_q.push_back(model(op_a, op_b, cin, sub));
         end
         q_len[gi] = exp_q.size();
      end
   end

   // Present one beat to instance 0 and hold it until it is accepted.
   task automatic drive_beat(input logic [63:0] a, input logic [63:0] b,
                             input logic c, input logic sb);
      int w;
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = a; op_b = b; cin = c; sub = sb;
      w = 0;
      @(negedge clk);
      while (!o_inrdy[0] && w < 20) begin
         w++;
         @(negedge clk);
      end
      chk("beat_accepted", 67'(o_inrdy[0]), 67'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait for instance 0's result; latency counts from the presenting cycle.
   task automatic expect_result(input string tag, input logic [31:0] es,
                                input logic ec, input logic eo, input logic ez);
      int lat;
      lat = 1;
      @(negedge clk);
      while (!o_valid[0] && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, 67'(lat), 67'(2));
      chk({tag, "_sum"}, 67'(o_sum[0]), 67'(es));
      chk({tag, "_cout"}, 67'(o_cout[0]), 67'(ec));
      chk({tag, "_overflow"}, 67'(o_ovf[0]), 67'(eo));
      chk({tag, "_zero"}, 67'(o_zero[0]), 67'(ez));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int bi, cyc;
      int base [NI];

      // Reset with in_valid high: the beat must be ignored.
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      op_a = 64'd5; op_b = 64'd6; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 67'(o_valid[0]), 67'(0));
      chk("reset_in_ready", 67'(o_inrdy[0]), 67'(1));
      chk("reset_sum", 67'(o_sum[0]), 67'(0));
      chk("reset_cout", 67'(o_cout[0]), 67'(0));
      chk("reset_overflow", 67'(o_ovf[0]), 67'(0));
      chk("reset_zero", 67'(o_zero[0]), 67'(0));
      repeat (3) @(negedge clk);
      chk("reset_no_ghost_beat", 67'(o_valid[0]), 67'(0));

      // Directed add/sub cases on instance 0.
      drive_beat(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0);
      expect_result("add_wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      drive_beat(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0);
      expect_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      drive_beat(64'h8000_0000, 64'h1, 1'b0, 1'b1);
      expect_result("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      drive_beat(64'd5, 64'd7, 1'b1, 1'b1);
      expect_result("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);

      // Backpressure: consumer stalls for 5 cycles.
      base[0] = res_cnt[0];
      bi = 0; cyc = 0;
      while (bi < 6 && cyc < 40) begin
         @(posedge clk); #1;
         out_ready = (cyc >= 5);
         in_valid  = 1'b1;
         op_a = 64'(bi); op_b = 64'(bi * 256); cin = 1'b0; sub = 1'b0;
         @(negedge clk);
         if (cyc == 2) begin
            chk("bp_in_ready_dropped", 67'(o_inrdy[0]), 67'(0));
            chk("bp_accepted_before_drop", 67'(bi), 67'(2));
            chk("bp_out_valid", 67'(o_valid[0]), 67'(1));
         end
         if (cyc == 4) begin
            chk("bp_still_stalled", 67'(o_inrdy[0]), 67'(0));
            chk("bp_held_sum", 67'(o_sum[0]), 67'(0));
         end
         if (in_valid && o_inrdy[0]) bi++;
         cyc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_all_accepted", 67'(bi), 67'(6));
      repeat (12) @(negedge clk);
      chk("bp_result_count", 67'(res_cnt[0] - base[0]), 67'(6));
      chk("bp_drained", 67'(q_len[0]), 67'(0));

      // Mid-flight reset: two beats in, reset, nothing may come out.
      @(posedge clk); #1;
      in_valid = 1'b1; op_a = 64'd1; op_b = 64'd1; out_ready = 1'b1;
      @(negedge clk);
      chk("mr_accept1", 67'(o_inrdy[0]), 67'(1));
      @(posedge clk); #1;
      op_a = 64'd2; op_b = 64'd2; out_ready = 1'b0;
      @(negedge clk);
      chk("mr_accept2", 67'(o_inrdy[0]), 67'(1));
      chk("mr_no_out_yet", 67'(o_valid[0]), 67'(0));
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("mr_out_valid_c%0d", i), 67'(o_valid[0]), 67'(0));
      end
      chk("mr_in_ready", 67'(o_inrdy[0]), 67'(1));
      drive_beat(64'd3, 64'd4, 1'b0, 1'b0);
      expect_result("mr_new_beat", 32'd7, 1'b0, 1'b0, 1'b0);
      repeat (6) @(negedge clk);

      // Random back-to-back sweep on every configuration.
      for (int i = 0; i < NI; i++) base[i] = res_cnt[i];
      for (int n = 0; n < 1000; n++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; out_ready = 1'b1;
         op_a = (n % 50 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
         op_b = (n % 50 == 1) ? 64'h0 : {$urandom, $urandom};
         cin  = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         sweep_cyc = n;
         sweep_on  = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; sweep_on = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("sweep_count_%0d", i), 67'(res_cnt[i] - base[i]), 67'(1000));
         chk($sformatf("sweep_drained_%0d", i), 67'(q_len[i]), 67'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
